// File: rtl/axis_moving_window_integrator.sv
// Moving-window integrator for the QRS-detection chain: emits the mean of the
// last 2**WIN_LOG2 unsigned samples for every sample accepted on the slave port.
module axis_moving_window_integrator #(
    parameter int WIN_LOG2 = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser
);

    localparam int WIN_LEN = 2 ** WIN_LOG2;
    localparam int SUM_W   = DATA_W + WIN_LOG2;
    localparam int FILL_W  = WIN_LOG2 + 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WIN_LOG2-1:0] clr_ptr;
    logic [WIN_LOG2-1:0] wr_ptr;
    logic [FILL_W-1:0]   fill_cnt;
    logic [SUM_W-1:0]    running_sum;
    logic [SUM_W-1:0]    sum_next;
    logic [DATA_W-1:0]   win_buf [WIN_LEN];
    logic [DATA_W-1:0]   old_sample;
    logic                primed_next;
    logic                accept;
    logic                consume;
    logic                buf_we;
    logic [WIN_LOG2-1:0] buf_addr;
    logic [DATA_W-1:0]   buf_wdata;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        unique case (state_q)
            CLEAR: begin
                if (&clr_ptr) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                s_axis_tready = ~m_axis_tvalid | m_axis_tready;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept  = s_axis_tvalid & s_axis_tready;
    assign consume = m_axis_tvalid & m_axis_tready;

    // The running sum always equals the exact buffer contents, so SUM_W bits
    // can neither overflow nor underflow.
    assign old_sample  = win_buf[wr_ptr];
    assign sum_next    = running_sum + SUM_W'(s_axis_tdata) - SUM_W'(old_sample);
    assign primed_next = (fill_cnt >= FILL_W'(WIN_LEN - 1));

    always_comb begin
        buf_we    = 1'b0;
        buf_addr  = wr_ptr;
        buf_wdata = s_axis_tdata;
        if (state_q == CLEAR) begin
            buf_we    = 1'b1;
            buf_addr  = clr_ptr;
            buf_wdata = '0;
        end else if (accept) begin
            buf_we = 1'b1;
        end
    end

    // NOTE: the window storage has no reset; the CLEAR sweep zeroes it after
    // every reset release, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            win_buf[buf_addr] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            running_sum <= '0;
        end else begin
            if (state_q == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (accept) begin
                wr_ptr      <= wr_ptr + 1'b1;
                running_sum <= sum_next;
                if (fill_cnt != FILL_W'(WIN_LEN)) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    // A new result takes priority over clearing, so a same-cycle consume and
    // accept keeps m_axis_tvalid high with fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sum_next[SUM_W-1:WIN_LOG2];
            m_axis_tuser  <= primed_next;
        end else if (consume) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    property p_hold_under_backpressure;
        @(posedge clk) disable iff (!rst_n)
            (m_axis_tvalid && !m_axis_tready) |=>
                (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tuser));
    endproperty
    a_hold_under_backpressure: assert property (p_hold_under_backpressure);

    property p_run_is_sticky;
        @(posedge clk) disable iff (!rst_n) (state_q == RUN) |=> (state_q == RUN);
    endproperty
    a_run_is_sticky: assert property (p_run_is_sticky);

endmodule

// File: tb/tb_axis_moving_window_integrator.sv
// Self-checking bench: directed scenarios plus randomized traffic, scored
// against a queue-based model of the windowed mean.
module tb_axis_moving_window_integrator;

    localparam int L2  = 2;
    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        m_user;

    logic        s_valid5 = 1'b1;
    logic [31:0] s_data5  = 32'd0;
    logic        s_ready5;
    logic        m_valid5;
    logic [31:0] m_data5;
    logic        m_ready5 = 1'b1;
    logic        m_user5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hist[$];
    logic [32:0] exp_q[$];
    logic [32:0] seen[$];
    int          run_cnt = 0;
    bit          exp_run;
    bit          exp_ready;
    int          clr_cycles;

    always #5 clk = ~clk;

    axis_moving_window_integrator #(.WIN_LOG2(L2), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tready(s_ready),
        .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tready(m_ready),
        .m_axis_tuser(m_user)
    );

    axis_moving_window_integrator #(.WIN_LOG2(5), .DATA_W(32)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_valid5), .s_axis_tdata(s_data5), .s_axis_tready(s_ready5),
        .m_axis_tvalid(m_valid5), .m_axis_tdata(m_data5), .m_axis_tready(m_ready5),
        .m_axis_tuser(m_user5)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Mean of the most recent WIN samples since the clear; absent samples are zero.
    function automatic logic [32:0] model_out();
        logic [63:0] sum = 64'd0;
        int n = hist.size();
        for (int i = (n > WIN) ? n - WIN : 0; i < n; i++) begin
            sum += 64'(hist[i]);
        end
        return {n >= WIN, sum[L2 +: 32]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            check("rst_m_user", m_user, 0);
            check("rst_s_ready", s_ready, 0);
            exp_q.delete();
            hist.delete();
            run_cnt = 0;
        end else begin
            exp_run   = (run_cnt >= WIN);
            exp_ready = exp_run && (exp_q.size() == 0 || m_ready);
            check("m_valid", m_valid, exp_q.size() != 0);
            check("s_ready", s_ready, exp_ready);
            if (exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0][31:0]);
                check("m_user", m_user, exp_q[0][32]);
                if (m_ready) begin
                    seen.push_back({m_user, m_data});
                    void'(exp_q.pop_front());
                end
            end
            if (s_valid && exp_ready) begin
                hist.push_back(s_data);
                exp_q.push_back(model_out());
            end
            run_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("send_timeout", waited < 200, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic expect_seen(input string tag, input int idx, input logic user, input logic [31:0] data);
        if (idx < seen.size()) begin
            check(tag, seen[idx], {user, data});
        end else begin
            check({tag, "_count"}, seen.size(), idx + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        tick(3);
        check("rst5_m_valid", m_valid5, 0);
        check("rst5_m_data", m_data5, 0);
        check("rst5_m_user", m_user5, 0);
        check("rst5_s_ready", s_ready5, 0);
        rst_n = 1'b1;

        // Clear sweep of the 32-entry instance with upstream valid held high.
        clr_cycles = 0;
        @(negedge clk);
        while (!s_ready5 && clr_cycles < 100) begin
            check("clr5_m_valid", m_valid5, 0);
            clr_cycles++;
            @(negedge clk);
        end
        check("clr5_length", clr_cycles, 32);
        @(posedge clk);
        #1;

        seen.delete();
        for (int i = 1; i <= 5; i++) send(32'(4 * i));
        tick(2);
        expect_seen("ramp0", 0, 1'b0, 32'd1);
        expect_seen("ramp1", 1, 1'b0, 32'd3);
        expect_seen("ramp2", 2, 1'b0, 32'd6);
        expect_seen("ramp3", 3, 1'b1, 32'd10);
        expect_seen("ramp4", 4, 1'b1, 32'd14);

        seen.delete();
        for (int i = 0; i < 10; i++) send(32'd100);
        for (int i = 0; i < 4; i++) send(32'd0);
        tick(2);
        expect_seen("step9", 9, 1'b1, 32'd100);
        expect_seen("step10", 10, 1'b1, 32'd75);
        expect_seen("step11", 11, 1'b1, 32'd50);
        expect_seen("step12", 12, 1'b1, 32'd25);
        expect_seen("step13", 13, 1'b1, 32'd0);

        seen.delete();
        for (int i = 0; i < 6; i++) send(32'hFFFF_FFFF);
        tick(2);
        expect_seen("max2", 2, 1'b1, 32'hBFFF_FFFF);
        expect_seen("max3", 3, 1'b1, 32'hFFFF_FFFF);
        expect_seen("max5", 5, 1'b1, 32'hFFFF_FFFF);

        seen.delete();
        m_ready = 1'b0;
        send(32'd7);
        s_valid = 1'b1;
        s_data  = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_ready", s_ready, 0);
            check("bp_m_valid", m_valid, 1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("bp_release", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        tick(2);
        expect_seen("bp_first", 0, 1'b1, 32'hC000_0001);
        expect_seen("bp_second", 1, 1'b1, 32'h8000_0003);

        m_ready = 1'b0;
        send(32'd50);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_m_user", m_user, 0);
        check("midrst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        seen.delete();
        send(32'd8);
        tick(2);
        expect_seen("after_rst", 0, 1'b0, 32'd2);

        for (int i = 0; i < 1500; i++) begin
            rst_n   = !(i == 700 || i == 701);
            s_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       s_data = 32'hFFFF_FFFF;
                1:       s_data = $urandom_range(0, 1000);
                default: s_data = $urandom;
            endcase
            m_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick(3);
        check("drain_m_valid", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_moving_window_integrator.md
Name: axis_moving_window_integrator

Overview:
Moving-window integrator stage of the ECG QRS-detection chain, directly downstream of the squaring stage. Consumes 32-bit squared samples on an AXI-Stream slave and produces, per accepted sample, the mean of the last WIN_LEN samples on an AXI-Stream master. Window is a power of two, so the mean is the running sum right-shifted by WIN_LOG2. Feeds the peak/threshold detection stage.

Parameters:
WIN_LOG2, 5, log2 of window length; WIN_LEN = 2**WIN_LOG2 (32 samples = 160 ms at 200 Hz); legal range 1..8
DATA_W, 32, input/output sample width; samples are treated as unsigned, since squared values are never negative

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  upstream sample valid
s_axis_tdata  in  DATA_W  squared sample, unsigned
s_axis_tready  out  1  block can accept a sample this cycle
m_axis_tvalid  out  1  output sample valid
m_axis_tdata  out  DATA_W  window mean = running_sum >> WIN_LOG2
m_axis_tready  in  1  downstream ready
m_axis_tuser  out  1  window primed: at least WIN_LEN samples have been accepted since the clear finished

Behaviour:
- Reset: clock clk; reset rst_n, asynchronous, active-low.
  - Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0.
  - Internal reset values: running_sum=0, wr_ptr=0, fill_cnt=0, state=CLEAR.
- Storage: WIN_LEN x DATA_W circular buffer. It is not reset asynchronously; the CLEAR state zeroes it instead.
- FSM, two states:
  - CLEAR: writes 0 to buf[clr_ptr] each cycle, clr_ptr counting 0..WIN_LEN-1. s_axis_tready=0. After the write of entry WIN_LEN-1, go to RUN. CLEAR lasts exactly WIN_LEN cycles after reset release.
  - RUN: normal streaming. Never leaves RUN except on reset.
- Handshake:
  - s_axis_tready = (state==RUN) & (~m_axis_tvalid | m_axis_tready). This is a combinational path from m_axis_tready.
  - A transfer occurs when s_axis_tvalid & s_axis_tready are both high.
- On each accepted sample x:
  - old = buf[wr_ptr]
  - buf[wr_ptr] <= x
  - running_sum <= running_sum + x - old
  - wr_ptr <= wr_ptr+1, wrapping from WIN_LEN-1 to 0
  - fill_cnt increments and saturates at WIN_LEN
- Output register, loaded on the same clock edge as the accept:
  - m_axis_tdata <= (running_sum + x - old) >> WIN_LOG2, truncated to DATA_W
  - m_axis_tuser <= (fill_cnt+1 >= WIN_LEN)
  - m_axis_tvalid <= 1
- Latency: one cycle from input handshake to m_axis_tvalid. Throughput: one sample per cycle when m_axis_tready is held high.
- Output clear: when m_axis_tvalid & m_axis_tready and no new accept in that cycle, m_axis_tvalid <= 0.
- Simultaneous output consume and input accept in one cycle: the output register reloads with the new result and m_axis_tvalid stays 1.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0:
  - m_axis_tdata and m_axis_tuser are held stable.
  - s_axis_tready=0, so no sample is lost or overwritten.
- Width: running_sum is DATA_W+WIN_LOG2 bits, unsigned.
  - It can never overflow or underflow, because it always equals the exact sum of buffer contents.
  - The mean of all-max inputs is exactly 2**DATA_W-1.
- Priming: before the window fills, the missing samples count as zero, so the output is the partial sum / WIN_LEN with m_axis_tuser=0.
- Reset asserted mid-stream: all outputs return to reset values immediately, and the in-flight output is dropped. After release, CLEAR runs again and the old buffer contents have no effect.
- s_axis_tdata is ignored whenever s_axis_tready=0.

Test Plan:
1. Reset release, WIN_LOG2=5, s_axis_tvalid=1 -> s_axis_tready=0 for exactly 32 cycles, then 1; m_axis_tvalid=0 throughout CLEAR.
2. WIN_LOG2=2, m_axis_tready=1, inputs 4,8,12,16,20 back-to-back -> outputs 1,3,6,10,14 one cycle after each accept; m_axis_tuser = 0,0,0,1,1.
3. WIN_LOG2=2, ten samples of 100 then four samples of 0 -> outputs reach 100 once primed, then 75,50,25,0 as the window wraps.
4. Backpressure: one output pending, m_axis_tready=0 for 5 cycles, upstream valid -> tdata and tuser stable, s_axis_tready=0, next sample accepted only on the cycle tready returns; no sample dropped (check sums).
5. Max value: WIN_LOG2=2, 0xFFFFFFFF x6 -> primed output 0xFFFFFFFF, no wrap to small values.
6. Reset asserted mid-stream with an output pending -> outputs zero immediately; after release, CLEAR repeats and input 8 gives output 2 (WIN_LOG2=2), with no old data leaking in.
